instr_fetch: RTL

- Front-end fetch stage of the out-of-order RV32I core. Holds the PC and looks up a direct-mapped instruction cache; on a miss it fetches the word from the memory controller.
- Each fetched word is handed to the branch predictor, which then returns the next PC. The instruction is then issued, tagged with its prediction, to the instruction queue.
- Redirects the PC on ROB mispredict (jump_wrong) and waits while the predictor resolves a JALR.

---
 rtl/instr_fetch.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// Fetch stage: holds the PC, looks up a direct-mapped one-word-per-line I-cache,
// goes to memory on a miss, waits for the predictor, then issues to the IQ.
module instr_fetch #(
    parameter int          ICACHE_IDX_W = 6,
    parameter logic [31:0] RESET_PC     = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_done,
    input  logic [31:0] mem_instr,
    output logic        if_success,
    output logic [31:0] if_instr_pc_itself,
    output logic [31:0] if_instr_to_ask_for_prediction,
    input  logic        predictor_enable_if,
    input  logic        predictor_stall_if,
    input  logic [31:0] predict_jump_pc,
    input  logic        predicted_jump,
    input  logic        jump_wrong,
    input  logic [31:0] jump_to_pc_from_rob,
    input  logic        iq_full,
    output logic        issue_valid,
    output logic [31:0] issue_instr,
    output logic [31:0] issue_pc,
    output logic        issue_pred_jump
);
    localparam int LINES = 1 << ICACHE_IDX_W;
    localparam int TAG_W = 32 - ICACHE_IDX_W - 2;

    typedef enum logic [2:0] {FETCH, WAIT_MEM, WAIT_PRED, STALL_JALR, DRAIN} state_t;

    state_t                    state_reg;
    logic [31:0]               pc_reg;
    logic                      mem_req_reg;
    logic [31:0]               mem_addr_reg;
    logic                      if_success_reg;
    logic [31:0]               if_pc_reg;
    logic [31:0]               if_instr_reg;
    logic                      issue_valid_reg;
    logic [31:0]               issue_instr_reg;
    logic [31:0]               issue_pc_reg;
    logic                      issue_pred_reg;

    logic [LINES-1:0]          valid_reg;
    logic [TAG_W-1:0]          tag_mem  [LINES];
    logic [31:0]               data_mem [LINES];

    logic [ICACHE_IDX_W-1:0]   pc_idx;
    logic [TAG_W-1:0]          pc_tag;
    logic [ICACHE_IDX_W-1:0]   fill_idx;
    logic [TAG_W-1:0]          fill_tag;
    logic                      hit;
    logic                      fill_en;

    assign pc_idx   = pc_reg[ICACHE_IDX_W+1:2];
    assign pc_tag   = pc_reg[31:ICACHE_IDX_W+2];
    // The fill always targets the outstanding request, even if pc moved on a flush.
    assign fill_idx = mem_addr_reg[ICACHE_IDX_W+1:2];
    assign fill_tag = mem_addr_reg[31:ICACHE_IDX_W+2];
    assign hit      = valid_reg[pc_idx] && (tag_mem[pc_idx] == pc_tag);
    assign fill_en  = rdy && mem_done && (state_reg == WAIT_MEM || state_reg == DRAIN);

    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_mem[fill_idx]  <= fill_tag;
            data_mem[fill_idx] <= mem_instr;
        end
    end

    generate
        for (genvar gi = 0; gi < LINES; gi++) begin : g_valid
            always_ff @(posedge clk or negedge rst) begin
                if (!rst)
                    valid_reg[gi] <= 1'b0;
                else if (fill_en && fill_idx == ICACHE_IDX_W'(gi))
                    valid_reg[gi] <= 1'b1;
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= FETCH;
            pc_reg          <= RESET_PC;
            mem_req_reg     <= 1'b0;
            mem_addr_reg    <= 32'h0;
            if_success_reg  <= 1'b0;
            if_pc_reg       <= 32'h0;
            if_instr_reg    <= 32'h0;
            issue_valid_reg <= 1'b0;
            issue_instr_reg <= 32'h0;
            issue_pc_reg    <= 32'h0;
            issue_pred_reg  <= 1'b0;
        end else if (rdy) begin
            if_success_reg  <= 1'b0;
            issue_valid_reg <= 1'b0;
            if (jump_wrong) begin
                pc_reg <= jump_to_pc_from_rob;
                case (state_reg)
                    WAIT_MEM: begin
                        if (mem_done) begin
                            mem_req_reg <= 1'b0;
                            state_reg   <= FETCH;
                        end else begin
                            state_reg   <= DRAIN;
                        end
                    end
                    DRAIN: begin
                        if (mem_done) begin
                            mem_req_reg <= 1'b0;
                            state_reg   <= FETCH;
                        end
                    end
                    default: state_reg <= FETCH;
                endcase
            end else begin
                case (state_reg)
                    FETCH: begin
                        if (!iq_full) begin
                            if (hit) begin
                                if_success_reg <= 1'b1;
                                if_pc_reg      <= pc_reg;
                                if_instr_reg   <= data_mem[pc_idx];
                                state_reg      <= WAIT_PRED;
                            end else begin
                                mem_req_reg    <= 1'b1;
                                mem_addr_reg   <= pc_reg;
                                state_reg      <= WAIT_MEM;
                            end
                        end
                    end
                    WAIT_MEM: begin
                        if (mem_done) begin
                            mem_req_reg    <= 1'b0;
                            if_success_reg <= 1'b1;
                            if_pc_reg      <= pc_reg;
                            if_instr_reg   <= mem_instr;
                            state_reg      <= WAIT_PRED;
                        end
                    end
                    WAIT_PRED: begin
                        if (predictor_enable_if) begin
                            issue_valid_reg <= 1'b1;
                            issue_instr_reg <= if_instr_reg;
                            issue_pc_reg    <= if_pc_reg;
                            issue_pred_reg  <= predicted_jump;
                            if (predictor_stall_if) begin
                                state_reg <= STALL_JALR;
                            end else begin
                                pc_reg    <= predict_jump_pc;
                                state_reg <= FETCH;
                            end
                        end
                    end
                    STALL_JALR: begin
                        if (predictor_enable_if && !predictor_stall_if) begin
                            pc_reg    <= predict_jump_pc;
                            state_reg <= FETCH;
                        end
                    end
                    DRAIN: begin
                        if (mem_done) begin
                            mem_req_reg <= 1'b0;
                            state_reg   <= FETCH;
                        end
                    end
                    default: state_reg <= FETCH;
                endcase
            end
        end
    end

    // A flush also masks any pulse already on the wire in the cycle it arrives.
    assign if_success                     = if_success_reg & ~(rdy & jump_wrong);
    assign issue_valid                    = issue_valid_reg & ~(rdy & jump_wrong);
    assign mem_req                        = mem_req_reg;
    assign mem_addr                       = mem_addr_reg;
    assign if_instr_pc_itself             = if_pc_reg;
    assign if_instr_to_ask_for_prediction = if_instr_reg;
    assign issue_instr                    = issue_instr_reg;
    assign issue_pc                       = issue_pc_reg;
    assign issue_pred_jump                = issue_pred_reg;
endmodule
